// File: rtl/fifo_burst_ctrl.sv
// Burst read controller for an external FIFO: tracks occupancy, requests bursts
// from a sink, and streams each burst through a 2-entry skid buffer.
module fifo_burst_ctrl #(
  parameter int DEPTH_WIDTH = 9,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_LEN   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_wr_en_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  flush_i,
  output logic                  burst_req_o,
  input  logic                  burst_ack_i,
  output logic [DEPTH_WIDTH:0]  burst_len_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  dout_last_o,
  output logic                  burst_done_o,
  output logic [DEPTH_WIDTH:0]  level_o,
  output logic                  overflow_o,
  output logic [1:0]            state_o
);

  localparam int LW = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] FULL = LW'(1) << DEPTH_WIDTH;
  localparam logic [LW-1:0] BLEN = LW'(BURST_LEN);
  localparam logic [LW-1:0] ONE  = LW'(1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t                state, state_nxt;
  logic                  flush_pend, flush_clr;
  logic                  load_len;
  logic [LW-1:0]         len_val;
  logic [LW-1:0]         rd_remain, out_remain;
  logic [DATA_WIDTH-1:0] skid0, skid1;
  logic [1:0]            skid_cnt;
  logic                  in_flight;
  logic                  pop;
  logic [2:0]            occ;

  // Stream handshake: a word moves when dout_valid_o && dout_ready_i on a rising
  // edge; valid never depends on ready, and the presented word holds until taken.
  assign pop          = dout_valid_o & dout_ready_i;
  assign dout_valid_o = (skid_cnt != 2'd0);
  assign dout_o       = dout_valid_o ? skid0 : '0;
  assign dout_last_o  = dout_valid_o && (out_remain == ONE);
  assign burst_req_o  = (state == REQ);
  assign burst_done_o = (state == DONE);
  assign state_o      = state;

  // A word leaving the skid this cycle frees its slot for a new read.
  assign occ = {1'b0, skid_cnt} + {2'b00, in_flight} - {2'b00, pop};
  assign fifo_rd_en_o = (state == XFER) && (rd_remain != '0) &&
                        (level_o != '0) && (occ < 3'd2);

  always_comb begin
    state_nxt = state;
    load_len  = 1'b0;
    len_val   = burst_len_o;
    flush_clr = 1'b0;
    case (state)
      IDLE: begin
        if (level_o >= BLEN) begin
          load_len  = 1'b1;
          len_val   = BLEN;
          state_nxt = REQ;
        end else if (flush_pend && (level_o != '0)) begin
          load_len  = 1'b1;
          len_val   = level_o;
          flush_clr = 1'b1;
          state_nxt = REQ;
        end else if (flush_pend) begin
          flush_clr = 1'b1;
        end
      end
      REQ:     if (burst_ack_i) state_nxt = XFER;
      XFER:    if (pop && (out_remain == ONE)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_len_o <= '0;
      flush_pend  <= 1'b0;
      rd_remain   <= '0;
      out_remain  <= '0;
    end else begin
      state <= state_nxt;
      if (load_len) burst_len_o <= len_val;
      // A new flush pulse wins over a same-cycle clear so it is never lost.
      if (flush_i) flush_pend <= 1'b1;
      else if (flush_clr) flush_pend <= 1'b0;
      if ((state == REQ) && burst_ack_i) begin
        rd_remain  <= burst_len_o;
        out_remain <= burst_len_o;
      end else begin
        if (fifo_rd_en_o) rd_remain <= rd_remain - ONE;
        if (pop) out_remain <= out_remain - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= 1'b0;
      skid0     <= '0;
      skid1     <= '0;
      skid_cnt  <= 2'd0;
    end else begin
      in_flight <= fifo_rd_en_o;
      case ({in_flight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= fifo_rd_data_i;
          else skid1 <= fifo_rd_data_i;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= fifo_rd_data_i;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rd_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (fifo_wr_en_i && !fifo_rd_en_o) begin
        if (level_o == FULL) overflow_o <= 1'b1;
        else level_o <= level_o + ONE;
      end else if (!fifo_wr_en_i && fifo_rd_en_o) begin
        level_o <= level_o - ONE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed bench for fifo_burst_ctrl: a behavioural FIFO feeds the DUT, expected
// words and burst lengths are queued at stimulus time and popped by a monitor.
module tb_fifo_burst_ctrl;
  localparam int DW = 9;
  localparam int WW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          fifo_wr_en_i = 1'b0;
  logic          fifo_rd_en_o;
  logic [WW-1:0] fifo_rd_data_i;
  logic          flush_i = 1'b0;
  logic          burst_req_o;
  logic          burst_ack_i = 1'b0;
  logic [DW:0]   burst_len_o;
  logic [WW-1:0] dout_o;
  logic          dout_valid_o;
  logic          dout_ready_i = 1'b1;
  logic          dout_last_o;
  logic          burst_done_o;
  logic [DW:0]   level_o;
  logic          overflow_o;
  logic [1:0]    state_o;
  logic [WW-1:0] wr_data = '0;

  // second instance: 16-deep FIFO, never acknowledged, so it is never read
  logic          wr2 = 1'b0;
  logic          rd2;
  logic [WW-1:0] rd_data2 = '0;
  logic          req2, last2, valid2, done2, ovf2;
  logic [4:0]    len2, level2;
  logic [WW-1:0] dout2;
  logic [1:0]    state2;

  fifo_burst_ctrl #(.DEPTH_WIDTH(DW), .DATA_WIDTH(WW), .BURST_LEN(64)) dut (
    .clk(clk), .rst(rst), .fifo_wr_en_i(fifo_wr_en_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_rd_data_i(fifo_rd_data_i), .flush_i(flush_i), .burst_req_o(burst_req_o),
    .burst_ack_i(burst_ack_i), .burst_len_o(burst_len_o), .dout_o(dout_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i), .dout_last_o(dout_last_o),
    .burst_done_o(burst_done_o), .level_o(level_o), .overflow_o(overflow_o),
    .state_o(state_o)
  );

  fifo_burst_ctrl #(.DEPTH_WIDTH(4), .DATA_WIDTH(WW), .BURST_LEN(16)) dut_small (
    .clk(clk), .rst(rst), .fifo_wr_en_i(wr2), .fifo_rd_en_o(rd2),
    .fifo_rd_data_i(rd_data2), .flush_i(1'b0), .burst_req_o(req2),
    .burst_ack_i(1'b0), .burst_len_o(len2), .dout_o(dout2),
    .dout_valid_o(valid2), .dout_ready_i(1'b1), .dout_last_o(last2),
    .burst_done_o(done2), .level_o(level2), .overflow_o(ovf2), .state_o(state2)
  );

  // ---------------- behavioural FIFO (1-cycle read latency) ----------------
  logic [WW-1:0] fmem [0:511];
  logic [8:0]    wp, rp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_rd_data_i <= '0;
    end else begin
      if (fifo_wr_en_i) begin
        fmem[wp] <= wr_data;
        wp <= wp + 9'd1;
      end
      if (fifo_rd_en_o) begin
        fifo_rd_data_i <= fmem[rp];
        rp <= rp + 9'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [WW:0] exp_q[$];      // {last, data}
  logic [DW:0] exp_len_q[$];
  int checks = 0;
  int errors = 0;
  int req_cnt = 0, done_cnt = 0, rd_cnt = 0, xfer_cnt = 0;
  logic prev_req = 1'b0;
  bit rand_ready = 1'b0;
  logic [WW-1:0] seq = 16'h1000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt   = 0;
        xfer_cnt = 0;
        prev_req = 1'b0;
      end else begin
        if (burst_req_o && !prev_req) begin
          req_cnt++;
          if (exp_len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got burst_len_o=%0d expected no request", burst_len_o);
          end else begin
            check("burst_len", 32'(burst_len_o), 32'(exp_len_q.pop_front()));
          end
        end
        prev_req = burst_req_o;
        if (fifo_rd_en_o) begin
          check("rd_level_nonzero", 32'(level_o != '0), 32'd1);
          check("rd_outstanding_lt2",
                32'((rd_cnt - xfer_cnt - int'(dout_valid_o && dout_ready_i)) < 2), 32'd1);
          rd_cnt++;
        end
        if (dout_valid_o && dout_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected no word", {dout_last_o, dout_o});
          end else begin
            check("dout_word", 32'({dout_last_o, dout_o}), 32'(exp_q.pop_front()));
          end
          xfer_cnt++;
        end
        if (burst_done_o) done_cnt++;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (burst_req_o && !rst) begin
        @(posedge clk); #1 burst_ack_i = 1'b1;
        @(posedge clk); #1 burst_ack_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      dout_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic write_words(input int n, input int blen);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      fifo_wr_en_i = 1'b1;
      wr_data = seq;
      exp_q.push_back({((i + 1) % blen == 0) || (i == n - 1), seq});
      seq = seq + 16'd1;
    end
    @(posedge clk); #1 fifo_wr_en_i = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic check_idle_end(input string name, input int lvl);
    repeat (3) @(negedge clk);
    check({name, "_level"}, 32'(level_o), 32'(lvl));
    check({name, "_state"}, 32'(state_o), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  int r0, d0, base, n;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({burst_req_o, fifo_rd_en_o, dout_valid_o, dout_last_o,
                              burst_done_o, overflow_o}), 32'd0);
    check("rst_level_len", 32'({level_o, burst_len_o}), 32'd0);
    check("rst_dout_state", 32'({dout_o, state_o}), 32'd0);
    rst = 1'b0;

    // 64 words, ready held high
    d0 = done_cnt;
    exp_len_q.push_back(10'd64);
    write_words(64, 64);
    wait_done("burst64_done", d0 + 1, 400);
    check_idle_end("burst64", 0);

    // 10 words then flush
    d0 = done_cnt; r0 = req_cnt;
    exp_len_q.push_back(10'd10);
    write_words(10, 64);
    pulse_flush();
    wait_done("flush10_done", d0 + 1, 200);
    repeat (20) @(negedge clk);
    check("flush10_no_extra_req", 32'(req_cnt), 32'(r0 + 1));
    check_idle_end("flush10", 0);

    // 64 words with random ready
    rand_ready = 1'b1;
    d0 = done_cnt;
    exp_len_q.push_back(10'd64);
    write_words(64, 64);
    wait_done("rand64_done", d0 + 1, 2000);
    rand_ready = 1'b0;
    check_idle_end("rand64", 0);

    // 130 words: two full bursts, remainder of 2 drained by flush
    d0 = done_cnt; r0 = req_cnt;
    exp_len_q.push_back(10'd64);
    exp_len_q.push_back(10'd64);
    write_words(130, 64);
    wait_done("b130_two_done", d0 + 2, 800);
    repeat (10) @(negedge clk);
    check("b130_req_count", 32'(req_cnt), 32'(r0 + 2));
    check("b130_level", 32'(level_o), 32'd2);
    check("b130_state", 32'(state_o), 32'd0);
    exp_len_q.push_back(10'd2);
    pulse_flush();
    wait_done("b130_flush_done", d0 + 3, 100);
    check_idle_end("b130", 0);

    // small instance overflow
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1 wr2 = 1'b1;
    end
    @(posedge clk); #1 wr2 = 1'b0;
    @(negedge clk);
    check("ovf_flag", 32'(ovf2), 32'd1);
    check("ovf_level", 32'(level2), 32'd16);
    check("ovf_burst_len", 32'(len2), 32'd16);
    repeat (5) @(negedge clk);
    check("ovf_sticky", 32'(ovf2), 32'd1);
    check("ovf_level_hold", 32'(level2), 32'd16);
    check("ovf_no_read", 32'({rd2, valid2, last2, done2, dout2}), 32'd0);
    check("ovf_req_state", 32'({req2, state2}), 32'({1'b1, 2'd1}));

    // reset while word 20 is presented
    d0 = done_cnt;
    exp_len_q.push_back(10'd64);
    base = xfer_cnt;
    write_words(64, 64);
    n = 0;
    while (xfer_cnt < base + 19 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_word20", 32'(xfer_cnt), 32'(base + 19));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({burst_req_o, fifo_rd_en_o, dout_valid_o, dout_last_o,
                                  burst_done_o, overflow_o}), 32'd0);
    check("mid_rst_level_len", 32'({level_o, burst_len_o}), 32'd0);
    check("mid_rst_dout_state", 32'({dout_o, state_o}), 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("mid_no_done", 32'(done_cnt), 32'(d0));
    exp_len_q.push_back(10'd64);
    write_words(64, 64);
    wait_done("post_rst_done", d0 + 1, 400);
    check_idle_end("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
